// File: rtl/tnoc_axi_packet_mux_pkg.sv
// Shared types for the AXI-side packet mux: NoC config, flit layout, head/tail helpers.
package tnoc_axi_packet_mux_pkg;

    typedef struct packed {
        int virtual_channels;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

    localparam int FLIT_DATA_W = 16;

    typedef struct packed {
        logic                   head;
        logic                   tail;
        logic [FLIT_DATA_W-1:0] data;
    } tnoc_flit;

    function automatic logic is_head_flit(tnoc_flit f);
        return f.head;
    endfunction

    function automatic logic is_tail_flit(tnoc_flit f);
        return f.tail;
    endfunction

    // VC index width, never narrower than one bit
    function automatic int vc_width(int vcs);
        return (vcs > 1) ? $clog2(vcs) : 1;
    endfunction

endpackage

// File: rtl/tnoc_axi_packet_mux_if.sv
// Flit bundle between the AXI adapters, the mux and the router local port.
interface tnoc_axi_packet_mux_if
    import tnoc_axi_packet_mux_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int VCS   = 2
) ();
    localparam int VC_WIDTH = vc_width(VCS);

    logic     [PORTS-1:0]               i_valid;
    logic     [PORTS-1:0]               o_ready;
    tnoc_flit [PORTS-1:0]               i_flit;
    logic     [PORTS-1:0][VC_WIDTH-1:0] i_vc;
    logic     [VCS-1:0]                 o_valid;
    logic     [VCS-1:0]                 i_ready;
    tnoc_flit                           o_flit;

    // mux side
    modport slave (
        input  i_valid, i_flit, i_vc, i_ready,
        output o_ready, o_valid, o_flit
    );

    // adapter / router side
    modport master (
        output i_valid, i_flit, i_vc, i_ready,
        input  o_ready, o_valid, o_flit
    );
endinterface

// File: rtl/tnoc_axi_packet_mux_arbiter.sv
// Packet-locked round-robin arbiter with per-grant burst credit.
module tnoc_axi_packet_mux_arbiter #(
    parameter int PORTS     = 2,
    parameter int MAX_BURST = 1,
    parameter int PW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req_i,
    input  logic             xfer_i,
    input  logic             head_i,
    input  logic             tail_i,
    output logic [PORTS-1:0] grant_o,
    output logic [PW-1:0]    grant_idx_o
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic          lock_q, lock_d;
    logic [PW-1:0] lock_port_q, lock_port_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          grant_vld;
    logic [PW-1:0] cand;
    int            scan_idx;
    logic [CW-1:0] cnt_base;
    int            cnt_new;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Grant: locked port, else first requester at or above rr_ptr (scan backwards so lowest offset wins)
    always_comb begin
        grant_vld   = 1'b0;
        grant_idx_o = '0;
        scan_idx    = 0;
        cand        = '0;
        if (lock_q) begin
            grant_vld   = 1'b1;
            grant_idx_o = lock_port_q;
        end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= PORTS) scan_idx = scan_idx - PORTS;
                cand = PW'(scan_idx);
                if (req_i[cand]) begin
                    grant_vld   = 1'b1;
                    grant_idx_o = cand;
                end
            end
        end
        grant_o = grant_vld ? (PORTS'(1) << grant_idx_o) : '0;
    end

    // Lock, pointer and burst-credit update on each accepted flit
    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        cnt_base    = burst_cnt_q;
        cnt_new     = 0;
        if (xfer_i) begin
            // a packet from a port other than the credit holder starts a fresh burst
            if (head_i && (grant_idx_o != rr_ptr_q)) cnt_base = '0;
            burst_cnt_d = cnt_base;
            if (head_i && !tail_i) begin
                lock_d      = 1'b1;
                lock_port_d = grant_idx_o;
            end
            if (tail_i) begin
                lock_d  = 1'b0;
                cnt_new = int'(cnt_base) + 1;
                if (cnt_new < MAX_BURST) begin
                    rr_ptr_d    = grant_idx_o;
                    burst_cnt_d = CW'(cnt_new);
                end else begin
                    rr_ptr_d    = (int'(grant_idx_o) == PORTS - 1) ? '0 : grant_idx_o + PW'(1);
                    burst_cnt_d = '0;
                end
            end
        end
    end

endmodule

// File: rtl/tnoc_axi_packet_mux.sv
// N-input packet mux onto one registered local flit output with one-hot per-VC valid.
module tnoc_axi_packet_mux
    import tnoc_axi_packet_mux_pkg::*;
#(
    parameter tnoc_config CONFIG    = TNOC_DEFAULT_CONFIG,
    parameter int         PORTS     = 2,
    parameter int         MAX_BURST = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    tnoc_axi_packet_mux_if.slave bus
);
    localparam int VCS      = CONFIG.virtual_channels;
    localparam int VC_WIDTH = vc_width(VCS);
    localparam int PW       = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [VCS-1:0]      o_valid_q, o_valid_d;
    tnoc_flit            o_flit_q, o_flit_d;
    logic [VC_WIDTH-1:0] vc_q, vc_d;

    logic [PORTS-1:0]    grant;
    logic [PW-1:0]       grant_idx;
    tnoc_flit            flit_sel;
    logic [VC_WIDTH-1:0] vc_sel;
    logic                out_free, xfer, head, tail;

    // Register is free when empty or being drained this cycle
    assign out_free = (o_valid_q == '0) || ((o_valid_q & bus.i_ready) != '0);
    assign flit_sel = bus.i_flit[grant_idx];
    assign head     = is_head_flit(flit_sel);
    assign tail     = is_tail_flit(flit_sel);
    // body flits follow the VC latched from their head
    assign vc_sel   = head ? bus.i_vc[grant_idx] : vc_q;

    assign bus.o_ready = grant & {PORTS{out_free}};
    assign xfer        = |(bus.i_valid & bus.o_ready);
    assign bus.o_valid = o_valid_q;
    assign bus.o_flit  = o_flit_q;

    tnoc_axi_packet_mux_arbiter #(
        .PORTS    (PORTS),
        .MAX_BURST(MAX_BURST),
        .PW       (PW)
    ) u_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (bus.i_valid),
        .xfer_i     (xfer),
        .head_i     (head),
        .tail_i     (tail),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    // Output register and locked VC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q <= '0;
            o_flit_q  <= '0;
            vc_q      <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_flit_q  <= o_flit_d;
            vc_q      <= vc_d;
        end
    end

    // Load on accept (may overlap a drain), clear valid on drain-only, otherwise hold
    always_comb begin
        o_valid_d = o_valid_q;
        o_flit_d  = o_flit_q;
        vc_d      = vc_q;
        if (xfer) begin
            o_valid_d = VCS'(1) << vc_sel;
            o_flit_d  = flit_sel;
            if (head) vc_d = vc_sel;
        end else if (out_free) begin
            o_valid_d = '0;
        end
    end

endmodule
